result_monitor: RTL and testbench
=================================

// Module: result_monitor
// PURPOSE
//  Receiving end of the 3-bit dice/traffic result bus. Samples sel/result each clock and checks legality:
//  in traffic mode, that the lights follow the red->red+amber->green->amber cycle; in dice mode, that the
//  face is 1..6. Keeps per-face cycle histograms and a saturating error count. Sits beside the mux
//  output as an on-chip checker and statistics gatherer.
// PARAMETERS
//  CNT_W       16  width of err_count and each histogram counter (saturating)
//  ALLOW_HOLD  1   1: repeating the current traffic pattern is legal; 0: must advance every cycle
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  sel          in   1      mode of the result bus: 0 = dice, 1 = traffic lights
//  result       in   3      mux output; traffic bits = {red,amber,green}; dice = face value
//  hist_sel     in   3      face (1..6) whose histogram count is presented on hist_count
//  traffic_err  out  1      1-cycle pulse: illegal traffic pattern or transition
//  dice_err     out  1      1-cycle pulse: dice value 0 or 7
//  mode_change  out  1      1-cycle pulse: sel differs from previous sample
//  locked       out  1      traffic sequence tracker synchronised
//  err_count    out  CNT_W  saturating count of traffic_err + dice_err pulses
//  hist_count   out  CNT_W  count for face hist_sel; 0 when hist_sel is 0 or 7 (combinational read)
// BEHAVIOUR
//  - Reset: all outputs 0, all histograms 0, tracker UNLOCKED, prev_sel 0. Reset mid-run clears
//    everything at that edge; the first post-reset sample is never a transition check, never mode_change.
//  - Latency: flags/counters reflect the sample taken at edge k and are valid after edge k
//    (registered, one cycle after inputs settle).
//  - Legal traffic patterns: R=3'b100, RA=3'b110, G=3'b001, A=3'b010. Order R->RA->G->A->R.
//  - Tracker FSM: UNLOCKED, S_R, S_RA, S_G, S_A. locked = (state != UNLOCKED).
//    * sel=0: state forced UNLOCKED.
//    * sel=1, UNLOCKED: legal pattern -> matching state, no error; illegal -> traffic_err, stay UNLOCKED.
//    * sel=1, locked: successor pattern -> advance; same pattern -> stay if ALLOW_HOLD else traffic_err;
//      other legal pattern -> traffic_err, resync to that pattern's state; illegal -> traffic_err, UNLOCKED.
//  - Dice (sel=0): value 1..6 -> increment that face's histogram (every cycle, held values count);
//    0 or 7 -> dice_err, no histogram change.
//  - Mode change: sample with sel != prev_sel pulses mode_change; that sample is treated as the first in
//    the new mode (traffic: from UNLOCKED; no transition error). Errors on that sample still reported.
//  - traffic_err and dice_err are mutually exclusive (selected by sel); err_count +1 per error cycle.
//  - All counters saturate at 2^CNT_W-1, never wrap.
// STRUCTURE
//  - Shared package result_pkg: traffic pattern constants (R/RA/G/A), DICE_MIN=1/DICE_MAX=6,
//    tracker state encoding.
//  - Sub-module traffic_seq_checker: tracker FSM, outputs locked + illegal pulse. Histogram array,
//    err_count and mode-change detect in result_monitor.
// TESTING
//  1 rst=1 two cycles, then sel=1, result 100,110,001,010,100 -> locked=1 from first sample, no errors.
//  2 Locked at S_G, drive 100 -> traffic_err pulse, state S_R, err_count=1; next 110 -> no error.
//  3 sel=1 result 3'b111 -> traffic_err, locked=0; then 010 -> locked=1, no error.
//  4 ALLOW_HOLD=0: 100,100 -> traffic_err on second; ALLOW_HOLD=1 same stimulus -> no error.
//  5 sel=0 result 3 for 4 cycles, 0 once, 7 once -> hist_count(3)=4, dice_err x2, err_count=2.
//  6 Toggle sel 1->0->1 mid-sequence (resume at 001) -> mode_change on each toggle, locked=0 during
//    dice, relock on 001 with no traffic_err; rst mid-run clears counters next edge; CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/result_pkg.sv
// Shared definitions for the result-bus monitor: traffic light patterns,
// dice face range and the traffic tracker state encoding.
package result_pkg;

  localparam logic [2:0] PAT_R    = 3'b100;
  localparam logic [2:0] PAT_RA   = 3'b110;
  localparam logic [2:0] PAT_G    = 3'b001;
  localparam logic [2:0] PAT_A    = 3'b010;
  localparam logic [2:0] DICE_MIN = 3'd1;
  localparam logic [2:0] DICE_MAX = 3'd6;

  typedef enum logic [2:0] {
    ST_UNLOCKED = 3'd0,
    ST_R        = 3'd1,
    ST_RA       = 3'd2,
    ST_G        = 3'd3,
    ST_A        = 3'd4
  } tstate_e;

  // Maps a light pattern to the tracker state it represents; illegal patterns map to UNLOCKED.
  function automatic tstate_e pattern_state(input logic [2:0] pat);
    tstate_e st;
    case (pat)
      PAT_R:   st = ST_R;
      PAT_RA:  st = ST_RA;
      PAT_G:   st = ST_G;
      PAT_A:   st = ST_A;
      default: st = ST_UNLOCKED;
    endcase
    return st;
  endfunction

  function automatic tstate_e succ_state(input tstate_e cur);
    tstate_e st;
    case (cur)
      ST_R:    st = ST_RA;
      ST_RA:   st = ST_G;
      ST_G:    st = ST_A;
      ST_A:    st = ST_R;
      default: st = ST_UNLOCKED;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/traffic_seq_checker.sv
// Traffic light sequence tracker: locks onto the R->RA->G->A cycle and flags
// illegal patterns or transitions for the current sample.
module traffic_seq_checker
  import result_pkg::*;
#(
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic [2:0] result,
  output logic       locked,
  output logic       illegal
);

  tstate_e state_r;
  tstate_e state_next_s;
  tstate_e pat_s;
  logic    locked_r;

  // Next-state and illegal-sample decode; illegal is for the sample being taken this edge.
  always_comb begin
    pat_s        = pattern_state(result);
    state_next_s = state_r;
    illegal      = 1'b0;
    if (!sel) begin
      state_next_s = ST_UNLOCKED;
    end else if (state_r == ST_UNLOCKED) begin
      state_next_s = pat_s;
      illegal      = (pat_s == ST_UNLOCKED);
    end else if (pat_s == ST_UNLOCKED) begin
      state_next_s = ST_UNLOCKED;
      illegal      = 1'b1;
    end else if (pat_s == succ_state(state_r)) begin
      state_next_s = pat_s;
    end else if (pat_s == state_r) begin
      state_next_s = state_r;
      illegal      = !ALLOW_HOLD;
    end else begin
      // A different legal pattern: report, then resync so the next sample is checked against it.
      state_next_s = pat_s;
      illegal      = 1'b1;
    end
  end

  // Tracker state register with registered lock flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_UNLOCKED;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      locked_r <= (state_next_s != ST_UNLOCKED);
    end
  end

  assign locked = locked_r;

endmodule

// File: rtl/result_monitor.sv
// On-chip checker for the dice/traffic result bus: legality flags, mode-change
// detect, saturating error count and per-face dice histograms.
module result_monitor
  import result_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [2:0]       result,
  input  logic [2:0]       hist_sel,
  output logic             traffic_err,
  output logic             dice_err,
  output logic             mode_change,
  output logic             locked,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] hist_count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] hist_r [DICE_MIN:DICE_MAX];
  logic [CNT_W-1:0] err_count_r;
  logic             traffic_err_r;
  logic             dice_err_r;
  logic             mode_change_r;
  logic             prev_sel_r;
  logic             primed_r;
  logic             traffic_illegal_s;
  logic             dice_err_s;

  traffic_seq_checker #(
    .ALLOW_HOLD (ALLOW_HOLD)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .result  (result),
    .locked  (locked),
    .illegal (traffic_illegal_s)
  );

  assign dice_err_s = !sel && ((result == 3'd0) || (result == 3'd7));

  // Flag pulses, error count and histograms for the sample taken at this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      traffic_err_r <= 1'b0;
      dice_err_r    <= 1'b0;
      mode_change_r <= 1'b0;
      prev_sel_r    <= 1'b0;
      primed_r      <= 1'b0;
      err_count_r   <= CNT_ZERO;
      for (int i = DICE_MIN; i <= DICE_MAX; i++) begin
        hist_r[i] <= CNT_ZERO;
      end
    end else begin
      traffic_err_r <= traffic_illegal_s;
      dice_err_r    <= dice_err_s;
      // primed_r keeps the first sample after reset from counting as a mode change.
      mode_change_r <= primed_r && (sel != prev_sel_r);
      prev_sel_r    <= sel;
      primed_r      <= 1'b1;
      if ((traffic_illegal_s || dice_err_s) && (err_count_r != CNT_MAX)) begin
        err_count_r <= err_count_r + CNT_ONE;
      end
      for (int i = DICE_MIN; i <= DICE_MAX; i++) begin
        if (!sel && (result == 3'(i)) && (hist_r[i] != CNT_MAX)) begin
          hist_r[i] <= hist_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Combinational histogram read port.
  always_comb begin
    hist_count = CNT_ZERO;
    if ((hist_sel >= DICE_MIN) && (hist_sel <= DICE_MAX)) begin
      hist_count = hist_r[hist_sel];
    end else begin
      hist_count = CNT_ZERO;
    end
  end

  assign traffic_err = traffic_err_r;
  assign dice_err    = dice_err_r;
  assign mode_change = mode_change_r;
  assign err_count   = err_count_r;

endmodule

// File: tb/tb_result_monitor.sv
// Scoreboard bench for result_monitor: three instances (default, no-hold, 2-bit
// counters) share stimulus; a pattern-index reference model predicts each output.
module tb_result_monitor;

  typedef struct {
    bit te;
    bit de;
    bit mc;
    bit lk;
    int ec;
    int hc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [2:0] result = 3'd0;
  logic [2:0] hist_sel = 3'd0;

  logic       te [3];
  logic       de [3];
  logic       mc [3];
  logic       lk [3];
  logic [15:0] ec0, ec1, hc0, hc1;
  logic [1:0]  ec2, hc2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int total  = 0;
  int passed = 0;

  // Reference model state per instance
  logic [2:0] pats [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
  int  m_idx  [3];
  int  m_ec   [3];
  int  m_hist [3][8];
  bit  m_prim [3];
  bit  m_psel [3];
  int  m_max  [3] = '{65535, 65535, 3};
  bit  m_hold [3] = '{1'b1, 1'b0, 1'b1};

  result_monitor #(.CNT_W(16), .ALLOW_HOLD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .sel(sel), .result(result), .hist_sel(hist_sel),
    .traffic_err(te[0]), .dice_err(de[0]), .mode_change(mc[0]), .locked(lk[0]),
    .err_count(ec0), .hist_count(hc0));

  result_monitor #(.CNT_W(16), .ALLOW_HOLD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .result(result), .hist_sel(hist_sel),
    .traffic_err(te[1]), .dice_err(de[1]), .mode_change(mc[1]), .locked(lk[1]),
    .err_count(ec1), .hist_count(hc1));

  result_monitor #(.CNT_W(2), .ALLOW_HOLD(1'b1)) dut2 (
    .clk(clk), .rst(rst), .sel(sel), .result(result), .hist_sel(hist_sel),
    .traffic_err(te[2]), .dice_err(de[2]), .mode_change(mc[2]), .locked(lk[2]),
    .err_count(ec2), .hist_count(hc2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  function automatic int find_pat(input logic [2:0] v);
    int p = -1;
    for (int k = 0; k < 4; k++) begin
      if (pats[k] == v) p = k;
    end
    return p;
  endfunction

  // Advance the model for one sample and return the expected outputs after the edge.
  function automatic exp_t model_step(input int m, input bit r, input bit s,
                                      input logic [2:0] v, input logic [2:0] hs);
    exp_t e;
    int p;
    e.te = 1'b0; e.de = 1'b0; e.mc = 1'b0;
    if (r) begin
      m_idx[m] = -1; m_ec[m] = 0; m_prim[m] = 1'b0; m_psel[m] = 1'b0;
      for (int k = 0; k < 8; k++) m_hist[m][k] = 0;
    end else begin
      e.mc = m_prim[m] && (s != m_psel[m]);
      if (s) begin
        p = find_pat(v);
        if (m_idx[m] < 0) begin
          e.te = (p < 0);
        end else if (p < 0) begin
          e.te = 1'b1;
        end else if (p == (m_idx[m] + 1) % 4) begin
          e.te = 1'b0;
        end else if (p == m_idx[m]) begin
          e.te = !m_hold[m];
        end else begin
          e.te = 1'b1;
        end
        m_idx[m] = p;
      end else begin
        m_idx[m] = -1;
        e.de = (v == 3'd0) || (v == 3'd7);
        if (!e.de && m_hist[m][v] < m_max[m]) m_hist[m][v]++;
      end
      if ((e.te || e.de) && m_ec[m] < m_max[m]) m_ec[m]++;
      m_psel[m] = s;
      m_prim[m] = 1'b1;
    end
    e.lk = (m_idx[m] >= 0);
    e.ec = m_ec[m];
    e.hc = (hs >= 3'd1 && hs <= 3'd6) ? m_hist[m][hs] : 0;
    return e;
  endfunction

  task automatic drive(input bit r, input bit s, input logic [2:0] v);
    logic [2:0] hs;
    @(negedge clk);
    hs = 3'($urandom_range(0, 7));
    rst = r; sel = s; result = v; hist_sel = hs;
    q0.push_back(model_step(0, r, s, v, hs));
    q1.push_back(model_step(1, r, s, v, hs));
    q2.push_back(model_step(2, r, s, v, hs));
  endtask

  task automatic cmp_inst(input int m, input exp_t e, input bit a_te, input bit a_de,
                          input bit a_mc, input bit a_lk, input int a_ec, input int a_hc);
    chk($sformatf("traffic_err[%0d]", m), int'(a_te), int'(e.te));
    chk($sformatf("dice_err[%0d]", m), int'(a_de), int'(e.de));
    chk($sformatf("mode_change[%0d]", m), int'(a_mc), int'(e.mc));
    chk($sformatf("locked[%0d]", m), int'(a_lk), int'(e.lk));
    chk($sformatf("err_count[%0d]", m), a_ec, e.ec);
    chk($sformatf("hist_count[%0d]", m), a_hc, e.hc);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per edge once stimulus starts.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp_inst(0, e, te[0], de[0], mc[0], lk[0], int'(ec0), int'(hc0));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp_inst(1, e, te[1], de[1], mc[1], lk[1], int'(ec1), int'(hc1));
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      cmp_inst(2, e, te[2], de[2], mc[2], lk[2], int'(ec2), int'(hc2));
    end
  end

  initial begin
    int g;
    bit s;
    logic [2:0] v;
    // Reset, then a clean traffic cycle
    drive(1'b1, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 3'b100); drive(1'b0, 1'b1, 3'b110);
    drive(1'b0, 1'b1, 3'b001); drive(1'b0, 1'b1, 3'b010);
    drive(1'b0, 1'b1, 3'b100); drive(1'b0, 1'b1, 3'b110);
    // Skip from G back to R, then continue legally
    drive(1'b0, 1'b1, 3'b001); drive(1'b0, 1'b1, 3'b100);
    drive(1'b0, 1'b1, 3'b110);
    // Illegal pattern, then relock on amber
    drive(1'b0, 1'b1, 3'b111); drive(1'b0, 1'b1, 3'b010);
    // Hold: legal only where ALLOW_HOLD is set
    drive(1'b0, 1'b1, 3'b100); drive(1'b0, 1'b1, 3'b100);
    // Dice histogram and out-of-range faces
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 3'd3);
    drive(1'b0, 1'b0, 3'd0); drive(1'b0, 1'b0, 3'd7);
    // Mode toggles mid-sequence
    drive(1'b0, 1'b1, 3'b100); drive(1'b0, 1'b1, 3'b110);
    drive(1'b0, 1'b0, 3'd5);
    drive(1'b0, 1'b1, 3'b001); drive(1'b0, 1'b1, 3'b010);
    // Reset mid-run
    drive(1'b1, 1'b1, 3'b111);
    drive(1'b0, 1'b1, 3'b111);
    // Randomised traffic/dice mix
    s = 1'b1; g = 0;
    for (int n = 0; n < 800; n++) begin
      int r;
      if ($urandom_range(0, 14) == 0) s = ~s;
      if (s) begin
        r = $urandom_range(0, 99);
        if (r < 70) g = (g + 1) % 4;
        v = (r < 85) ? pats[g] : 3'($urandom_range(0, 7));
      end else begin
        v = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7)
                                        : 3'($urandom_range(1, 6));
      end
      drive(($urandom_range(0, 99) == 0), s, v);
    end
    drive(1'b0, 1'b0, 3'd2);
    repeat (3) @(posedge clk);
    #2;
    chk("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
